accum_pipelined_unit: RTL and testbench
=======================================

# accum_pipelined_unit

Parametrised, pipelined successor to the single-request accumulator unit. It walks a strided vector in memory and keeps up to `p_max_inflight` read requests outstanding. Returned words are reduced with a selectable operation (sum, unsigned max, unsigned min, xor) into a `p_result_nbits` result. It sits beside a processor as a memory-side accelerator on the standard `mem_req_4B_t`/`mem_resp_4B_t` val/rdy streams.

## Interface
- `p_max_inflight`, 4: max outstanding read requests, 1..16; also the response-queue depth.
- `p_result_nbits`, 32: result width, 32..64.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `go`  in  1  start pulse; sampled only in IDLE.
- `base_addr`  in  32  byte address of element 0; latched on accepted go.
- `size`  in  32  element count; latched on accepted go.
- `stride`  in  32  byte distance between elements; latched on accepted go.
- `mode`  in  2  reduction op: 0 sum, 1 umax, 2 umin, 3 xor; latched on accepted go.
- `done`  out  1  high for exactly one cycle when the result is final.
- `result`  out  p_result_nbits  reduction value; holds until the next accepted go.
- `mem_reqstream_msg`  out  mem_req_4B_t  read request; all-zero whenever val is low.
- `mem_reqstream_val`  out  1  request valid.
- `mem_reqstream_rdy`  in  1  memory accepts the request.
- `mem_respstream_msg`  in  mem_resp_4B_t  read response.
- `mem_respstream_val`  in  1  response valid.
- `mem_respstream_rdy`  out  1  not-full signal of the internal response queue.

## Operation
- **States**
  - IDLE: go transitions to RUN, or to DONE if size==0.
  - RUN: transitions to DONE in the cycle after the final response is consumed.
  - DONE: transitions unconditionally to IDLE.
- **Accepted go:** latches all inputs, clears `issue_idx`, `resp_cnt` and `inflight`, and loads `result` with the identity for the mode.
  - Identity is 0 for sum, umax and xor.
  - Identity is zero-extended 0xFFFFFFFF for umin.
- **Request issue (RUN):** `mem_reqstream_val` = (`issue_idx` < size) && (`inflight` < p_max_inflight).
  - Message fields: type READ, opaque = `issue_idx[7:0]`, addr = base_addr + `issue_idx`*stride (mod 2^32), len 0, data 0.
  - On val&&rdy: `issue_idx`++ and `inflight`++.
- **Response path:** responses enter a pipe queue of depth p_max_inflight and are consumed one per cycle in RUN.
  - On consume: `resp_cnt`++ and `inflight`--.
  - Same-cycle issue and consume leaves `inflight` unchanged.
- **Reduction:** response data is zero-extended to p_result_nbits.
  - sum: adds modulo 2^p_result_nbits.
  - umax / umin: unsigned compare.
  - xor: bitwise.
- Responses arrive in request order; no operation is order-sensitive, so opaque is informational only.
- go while not in IDLE is ignored.
- In IDLE and DONE: no requests are issued and the queue is not dequeued.

## Timing
- **Reset values:** state IDLE; `done`=0; `result`=0; `mem_reqstream_val`=0; `mem_reqstream_msg`=0; queue empty.
- **Request timing:** the first request is valid in the cycle after go. Peak rate is one request and one response per cycle.
- **Latency:**
  - With a 1-cycle memory: size N completes with `done` high at cycle N+3 after go, for p_max_inflight ≥ 2.
  - With p_max_inflight=1: one element per 3 cycles minimum.
- **Back-pressure:** `mem_reqstream_rdy` low holds msg and val stable. `issue_idx` does not advance.
- **Queue occupancy:** `mem_respstream_rdy` never drops while `inflight` ≤ depth is respected.
- **Result timing:** `result` is final in the `done` cycle and stays constant through IDLE until the next accepted go.
- **Reset mid-operation:** returns to reset values next cycle. The environment must discard responses to pre-reset requests.

## Configuration
- `ACCUM_SATURATE_EN` defined: in sum mode, overflow clamps `result` at 2^p_result_nbits−1 and sticks there for the rest of the operation.
- `ACCUM_SATURATE_EN` undefined: sum wraps modulo 2^p_result_nbits.
- Other modes are unaffected by the macro.

## Test plan
- **Basic sum:** sum mode, base 0x1000, stride 4, size 4, data 1,2,3,4, 1-cycle memory -> requests 0x1000,0x1004,0x1008,0x100C; result 10; `done` one cycle.
- **Modes and stride:** stride 8, size 3, data 5,0xFFFFFFFF,7.
  - umax -> 0xFFFFFFFF.
  - umin -> 5.
  - xor -> 0xFFFFFFFD.
  - Addresses base+0, +8, +16.
- **Size zero:** size 0 -> no requests; `done` the cycle after go. Result 0 in sum mode; 0xFFFFFFFF in umin mode.
- **Memory delays:** random memory delay 0-5 cycles and random `mem_reqstream_rdy` stalls, p_max_inflight=4, size 64 -> `inflight` never exceeds 4; result equals the golden sum.
- **Overflow, p_result_nbits=32:** sum of 0xFFFFFFFF, 2.
  - Without `ACCUM_SATURATE_EN` -> 1.
  - With `ACCUM_SATURATE_EN` -> 0xFFFFFFFF.
  - With p_result_nbits=64 -> 0x1_00000001.
- **Ignored go and reset:** go asserted again mid-RUN -> ignored. Reset asserted mid-RUN -> all outputs zero next cycle; a fresh go then completes correctly.

Source files
------------

// File: rtl/accum_pipelined_unit.sv
// accum_pipelined_unit: walks a strided vector with up to p_max_inflight reads outstanding and
// reduces the returned words (sum/umax/umin/xor). Optional macro ACCUM_SATURATE_EN clamps sum mode.

package mem_msgs_pkg;

    localparam logic [2:0] MEM_TYPE_READ = 3'd0;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

module accum_pipelined_unit
    import mem_msgs_pkg::*;
#(
    parameter int p_max_inflight = 4,
    parameter int p_result_nbits = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    input  logic [31:0]               base_addr,
    input  logic [31:0]               size,
    input  logic [31:0]               stride,
    input  logic [1:0]                mode,
    output logic                      done,
    output logic [p_result_nbits-1:0] result,
    output mem_req_4B_t               mem_reqstream_msg,
    output logic                      mem_reqstream_val,
    input  logic                      mem_reqstream_rdy,
    input  mem_resp_4B_t              mem_respstream_msg,
    input  logic                      mem_respstream_val,
    output logic                      mem_respstream_rdy,
    output logic [1:0]                state_dbg
);

    localparam int R  = p_result_nbits;
    localparam int IW = $clog2(p_max_inflight + 1);
    localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;

    localparam logic [1:0] MODE_SUM  = 2'd0;
    localparam logic [1:0] MODE_UMAX = 2'd1;
    localparam logic [1:0] MODE_UMIN = 2'd2;
    localparam logic [1:0] MODE_XOR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]   addr_r;
    logic [31:0]   size_r;
    logic [31:0]   stride_r;
    logic [1:0]    mode_r;
    logic [31:0]   issue_idx;
    logic [31:0]   resp_cnt;
    logic [IW-1:0] inflight;

    logic go_acc;
    logic issue;
    logic enq;
    logic deq;

    // Response queue: a small circular buffer holding only the data field.
    logic [31:0]   q_data [p_max_inflight];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] q_cnt;

    logic [R-1:0] resp_ext;
    logic [R-1:0] sum_val;
    logic [R-1:0] reduced;
    logic [R-1:0] identity;
    logic         resp_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(p_max_inflight - 1)) ? '0 : p + PW'(1);
    endfunction

    // Both streams use val/rdy: a beat transfers on the rising edge where val && rdy; while a
    // request waits for rdy its val and msg stay stable, and msg is all-zero whenever val is low.
    assign mem_reqstream_val  = (state == RUN) && (issue_idx < size_r)
                              && (inflight < IW'(p_max_inflight));
    assign mem_respstream_rdy = (q_cnt != IW'(p_max_inflight));

    assign issue = mem_reqstream_val && mem_reqstream_rdy;
    assign enq   = mem_respstream_val && mem_respstream_rdy;
    assign deq   = (state == RUN) && (q_cnt != '0);

    assign state_dbg   = state;
    assign resp_unused = ^{mem_respstream_msg.type_, mem_respstream_msg.opaque,
                           mem_respstream_msg.test, mem_respstream_msg.len};

    always_comb begin
        mem_reqstream_msg = '0;
        if (mem_reqstream_val) begin
            mem_reqstream_msg.type_  = MEM_TYPE_READ;
            mem_reqstream_msg.opaque = issue_idx[7:0];
            mem_reqstream_msg.addr   = addr_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go_acc     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    go_acc     = 1'b1;
                    state_next = (size == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (deq && (resp_cnt == size_r - 32'd1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_ext = R'(q_data[rd_ptr]);
    assign identity = (mode == MODE_UMIN) ? R'(32'hFFFF_FFFF) : '0;

`ifdef ACCUM_SATURATE_EN
    // A clamped all-ones result stays clamped: any nonzero addend overflows again.
    logic [R:0] sum_full;
    assign sum_full = {1'b0, result} + {1'b0, resp_ext};
    assign sum_val  = sum_full[R] ? '1 : sum_full[R-1:0];
`else
    assign sum_val = result + resp_ext;
`endif

    always_comb begin
        reduced = result;
        case (mode_r)
            MODE_SUM:  reduced = sum_val;
            MODE_UMAX: reduced = (resp_ext > result) ? resp_ext : result;
            MODE_UMIN: reduced = (resp_ext < result) ? resp_ext : result;
            MODE_XOR:  reduced = result ^ resp_ext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r    <= '0;
            size_r    <= '0;
            stride_r  <= '0;
            mode_r    <= '0;
            issue_idx <= '0;
            resp_cnt  <= '0;
            inflight  <= '0;
            result    <= '0;
        end else if (go_acc) begin
            addr_r    <= base_addr;
            size_r    <= size;
            stride_r  <= stride;
            mode_r    <= mode;
            issue_idx <= '0;
            resp_cnt  <= '0;
            inflight  <= '0;
            result    <= identity;
        end else begin
            if (issue) begin
                issue_idx <= issue_idx + 32'd1;
                addr_r    <= addr_r + stride_r;
            end
            if (deq) begin
                resp_cnt <= resp_cnt + 32'd1;
                result   <= reduced;
            end
            case ({issue, deq})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({enq, deq})
                2'b10:   q_cnt <= q_cnt + IW'(1);
                2'b01:   q_cnt <= q_cnt - IW'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[wr_ptr] <= mem_respstream_msg.data;
        end
    end

    a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
        inflight <= IW'(p_max_inflight));
    a_req_msg_zero: assert property (@(posedge clk) disable iff (reset)
        !mem_reqstream_val |-> (mem_reqstream_msg == '0));
    a_queue_bound: assert property (@(posedge clk) disable iff (reset)
        q_cnt <= IW'(p_max_inflight));

endmodule

// File: tb/tb_accum_pipelined_unit.sv
// Bench for accum_pipelined_unit: scoreboarded requests and results against a plain-arithmetic
// reduction model, with a randomized delaying/stalling memory; a 64-bit instance shares the streams.

module tb_accum_pipelined_unit;
    import mem_msgs_pkg::*;

    localparam int P = 4;
    localparam int R = 32;
`ifdef ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic [31:0]  base_addr, size, stride;
    logic [1:0]   mode;
    logic         done, done64;
    logic [R-1:0] result;
    logic [63:0]  result64;
    mem_req_4B_t  req_msg, req_msg64;
    logic         req_val, req_val64, req_rdy;
    mem_resp_4B_t resp_msg;
    logic         resp_val, resp_rdy, resp_rdy64;
    logic [1:0]   state_dbg, state_dbg64;

    accum_pipelined_unit #(.p_max_inflight(P), .p_result_nbits(R)) dut (
        .clk(clk), .reset(reset), .go(go), .base_addr(base_addr), .size(size),
        .stride(stride), .mode(mode), .done(done), .result(result),
        .mem_reqstream_msg(req_msg), .mem_reqstream_val(req_val), .mem_reqstream_rdy(req_rdy),
        .mem_respstream_msg(resp_msg), .mem_respstream_val(resp_val),
        .mem_respstream_rdy(resp_rdy), .state_dbg(state_dbg)
    );

    accum_pipelined_unit #(.p_max_inflight(P), .p_result_nbits(64)) dut64 (
        .clk(clk), .reset(reset), .go(go), .base_addr(base_addr), .size(size),
        .stride(stride), .mode(mode), .done(done64), .result(result64),
        .mem_reqstream_msg(req_msg64), .mem_reqstream_val(req_val64), .mem_reqstream_rdy(req_rdy),
        .mem_respstream_msg(resp_msg), .mem_respstream_val(resp_val),
        .mem_respstream_rdy(resp_rdy64), .state_dbg(state_dbg64)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass = 0;
    logic [R-1:0]  exp_q[$];
    logic [63:0]   exp64_q[$];
    mem_req_4B_t   exp_req_q[$];
    logic [31:0]   cur_data[$];
    logic [31:0]   mem_data[logic [31:0]];
    logic [R-1:0]  last_exp = '0;
    logic [63:0]   last_exp64 = '0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            go_cyc = 0;

    bit mem_rand = 1'b0;
    int max_delay = 0;
    int stall_pct = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  opaque;
        int          rdy_cyc;
    } pend_t;
    pend_t pend_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference reduction straight from the operation definitions.
    function automatic logic [63:0] ref_reduce(input logic [1:0] m, input int nbits);
        logic [64:0] acc;
        logic [64:0] mask;
        mask = (nbits == 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << nbits) - 65'd1);
        acc = (m == 2'd2) ? 65'h0_FFFF_FFFF : 65'd0;
        foreach (cur_data[i]) begin
            case (m)
                2'd0: begin
                    acc = acc + 65'(cur_data[i]);
                    if (acc > mask) acc = SAT ? mask : (acc & mask);
                end
                2'd1: if (65'(cur_data[i]) > acc) acc = 65'(cur_data[i]);
                2'd2: if (65'(cur_data[i]) < acc) acc = 65'(cur_data[i]);
                default: acc = acc ^ 65'(cur_data[i]);
            endcase
        end
        return acc[63:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill_rand(input int n);
        cur_data.delete();
        repeat (n) cur_data.push_back($urandom);
    endtask

    task automatic start_op(input logic [31:0] b, input logic [31:0] n, input logic [31:0] s,
                            input logic [1:0] m);
        mem_req_4B_t r;
        logic [31:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 32'(i) * s;
            mem_data[a] = cur_data[i];
            r = '0;
            r.type_ = MEM_TYPE_READ;
            r.opaque = 8'(i);
            r.addr = a;
            exp_req_q.push_back(r);
        end
        exp_q.push_back(R'(ref_reduce(m, R)));
        exp64_q.push_back(ref_reduce(m, 64));
        @(negedge clk);
        base_addr = b; size = n; stride = s; mode = m; go = 1'b1;
        go_cyc = cyc;
        @(negedge clk);
        go = 1'b0;
        base_addr = $urandom; size = $urandom; stride = $urandom; mode = 2'($urandom_range(3));
    endtask

    task automatic wait_done(input int budget, input int exp_lat);
        int start_cnt;
        int k;
        start_cnt = done_cnt;
        k = 0;
        while (done_cnt == start_cnt && k < budget) begin
            @(negedge clk); #4;
            k++;
        end
        check("done_seen", done_cnt != start_cnt, 1'b1);
        if (exp_lat >= 0 && done_cnt != start_cnt) check("done_latency", done_cyc - go_cyc, exp_lat);
        repeat (3) @(negedge clk);
        #4;
        check("result_hold", result, last_exp);
        check("result64_hold", result64, last_exp64);
    endtask

    // ---------------- memory model ----------------
    initial begin : memory
        pend_t p;
        bit prev_stall;
        mem_req_4B_t prev_msg;
        int outstanding;
        prev_stall = 1'b0;
        prev_msg = '0;
        outstanding = 0;
        req_rdy = 1'b0; resp_val = 1'b0; resp_msg = '0;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                pend_q.delete(); exp_req_q.delete();
                outstanding = 0; prev_stall = 1'b0;
                req_rdy = 1'b0; resp_val = 1'b0; resp_msg = '0;
            end else begin
                req_rdy = ($urandom_range(99) >= stall_pct);
                resp_msg = '0;
                resp_val = 1'b0;
                if (pend_q.size() > 0 && pend_q[0].rdy_cyc <= cyc) begin
                    resp_val = 1'b1;
                    resp_msg.type_ = MEM_TYPE_READ;
                    resp_msg.opaque = pend_q[0].opaque;
                    resp_msg.data = pend_q[0].data;
                end
                #1;
                if (prev_stall) begin
                    check("stall_hold_val", req_val, 1'b1);
                    check("stall_hold_msg", req_msg, prev_msg);
                end
                if (!req_val) check("req_msg_zero", req_msg, '0);
                prev_stall = req_val && !req_rdy;
                prev_msg = req_msg;
                if (req_val && req_rdy) begin
                    check("req_expected", exp_req_q.size() != 0, 1'b1);
                    if (exp_req_q.size() != 0) check("req_msg", req_msg, exp_req_q.pop_front());
                    outstanding++;
                    check("inflight_bound", outstanding <= P, 1'b1);
                    p.data = mem_data.exists(req_msg.addr) ? mem_data[req_msg.addr] : 32'd0;
                    p.opaque = req_msg.opaque;
                    p.rdy_cyc = cyc + 1 + (mem_rand ? int'($urandom_range(max_delay)) : 0);
                    pend_q.push_back(p);
                end
                if (resp_val) begin
                    check("resp_rdy", resp_rdy, 1'b1);
                    if (resp_rdy) begin
                        void'(pend_q.pop_front());
                        outstanding--;
                    end
                end
            end
        end
    end

    // ---------------- result monitor ----------------
    initial begin : monitor
        bit prev_done;
        bit prev_done64;
        prev_done = 1'b0;
        prev_done64 = 1'b0;
        forever begin
            @(negedge clk); #3;
            if (reset) begin
                prev_done = 1'b0;
                prev_done64 = 1'b0;
            end else begin
                if (done) begin
                    check("done_one_cycle", prev_done, 1'b0);
                    check("done_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        last_exp = exp_q.pop_front();
                        check("result", result, last_exp);
                    end
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (done64) begin
                    check("done64_expected", exp64_q.size() != 0, 1'b1);
                    if (exp64_q.size() != 0) begin
                        last_exp64 = exp64_q.pop_front();
                        check("result64", result64, last_exp64);
                    end
                end
                prev_done = done;
                prev_done64 = done64;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        reset = 1'b1; go = 1'b0;
        base_addr = '0; size = '0; stride = '0; mode = '0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_done", done, 1'b0);
        check("rst_req_val", req_val, 1'b0);
        check("rst_req_msg", req_msg, '0);
        check("rst_result", result, '0);
        check("rst_result64", result64, '0);
        @(negedge clk);
        reset = 1'b0;

        cur_data = '{32'd1, 32'd2, 32'd3, 32'd4};
        start_op(32'h1000, 32'd4, 32'd4, 2'd0);
        wait_done(50, 7);

        for (int m = 1; m <= 3; m++) begin
            cur_data = '{32'd5, 32'hFFFF_FFFF, 32'd7};
            start_op(32'h2000, 32'd3, 32'd8, 2'(m));
            wait_done(50, 6);
        end

        cur_data.delete();
        start_op(32'h3000, 32'd0, 32'd4, 2'd0);
        wait_done(10, 1);
        start_op(32'h3000, 32'd0, 32'd4, 2'd2);
        wait_done(10, 1);

        cur_data = '{32'hFFFF_FFFF, 32'd2};
        start_op(32'h4000, 32'd2, 32'd4, 2'd0);
        wait_done(50, 5);

        mem_rand = 1'b1; max_delay = 5; stall_pct = 30;
        fill_rand(64);
        start_op(32'h1_0000, 32'd64, 32'd4, 2'd0);
        wait_done(3000, -1);
        for (int t = 0; t < 6; t++) begin
            fill_rand($urandom_range(20, 1));
            start_op($urandom & 32'hFFFF_FFFC, 32'(cur_data.size()),
                     32'(4 * $urandom_range(64, 1)), 2'($urandom_range(3)));
            wait_done(2000, -1);
        end

        // A second go while running must not restart or perturb the walk.
        mem_rand = 1'b0; stall_pct = 0;
        fill_rand(8);
        start_op(32'h5000, 32'd8, 32'd4, 2'd3);
        repeat (3) @(negedge clk);
        go = 1'b1; size = 32'd2; base_addr = 32'h9000; mode = 2'd1;
        repeat (2) @(negedge clk);
        go = 1'b0;
        wait_done(100, 11);

        mem_rand = 1'b1; stall_pct = 20;
        fill_rand(16);
        start_op(32'h6000, 32'd16, 32'd4, 2'd0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        exp64_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("midrst_done", done, 1'b0);
        check("midrst_req_val", req_val, 1'b0);
        check("midrst_req_msg", req_msg, '0);
        check("midrst_result", result, '0);
        check("midrst_result64", result64, '0);
        mem_rand = 1'b0; stall_pct = 0;
        cur_data = '{32'd1, 32'd2, 32'd3, 32'd4};
        start_op(32'h1000, 32'd4, 32'd4, 2'd0);
        wait_done(50, 7);

        check("no_leftover_results", exp_q.size(), 0);
        check("no_leftover_requests", exp_req_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
